// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed non-restoring divider (quotient on Clow, remainder on Chigh)
// Optional early exit on a zero divisor: DIV_ZERO_DETECT_EN
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Clow,
    output logic [WIDTH-1:0] Chigh,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] clow_q, clow_d;
    logic [WIDTH-1:0] chigh_q, chigh_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   p_sh, p_step, p_fix;
    logic [WIDTH-1:0] q_sh, q_step;
    logic [WIDTH-1:0] rem_mag;

`ifdef DIV_ZERO_DETECT_EN
    assign b_zero = (B == '0);
`else
    assign b_zero = 1'b0;
`endif

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign abs_a  = A[WIDTH-1] ? -A : A;
    assign abs_b  = B[WIDTH-1] ? -B : B;

    // One non-restoring step: shift {P,Q}, add or subtract M by the sign of P.
    assign p_sh    = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_sh    = {q_q[WIDTH-2:0], 1'b0};
    assign p_step  = p_sh[WIDTH] ? (p_sh + {1'b0, m_q}) : (p_sh - {1'b0, m_q});
    assign q_step  = {q_sh[WIDTH-1:1], ~p_step[WIDTH]};
    assign p_fix   = p_q[WIDTH] ? (p_q + {1'b0, m_q}) : p_q;
    assign rem_mag = p_fix[WIDTH-1:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = b_zero ? S_FIX : S_ITER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_ITER) || (state_q == S_FIX);
        done        = (state_q == S_DONE);
        div_by_zero = (state_q == S_DONE) && dz_q;
        Clow        = clow_q;
        Chigh       = chigh_q;
    end

    always_comb begin
        p_d      = p_q;
        q_d      = q_q;
        m_d      = m_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        count_d  = count_q;
        clow_d   = clow_q;
        chigh_d  = chigh_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    p_d      = '0;
                    q_d      = abs_a;
                    m_d      = abs_b;
                    sign_a_d = A[WIDTH-1];
                    sign_b_d = B[WIDTH-1];
                    count_d  = '0;
                    dz_d     = b_zero;
                end
            end
            S_ITER: begin
                p_d     = p_step;
                q_d     = q_step;
                count_d = count_q + CNT_W'(1);
            end
            S_FIX: begin
                // On the zero-divisor shortcut Q still holds |A|, so re-signing it restores A.
                if (dz_q) begin
                    clow_d  = '1;
                    chigh_d = sign_a_q ? -q_q : q_q;
                end else begin
                    p_d     = p_fix;
                    clow_d  = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                    chigh_d = sign_a_q ? -rem_mag : rem_mag;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            p_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            count_q  <= '0;
            clow_q   <= '0;
            chigh_q  <= '0;
            dz_q     <= 1'b0;
        end else begin
            p_q      <= p_d;
            q_q      <= q_d;
            m_q      <= m_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            count_q  <= count_d;
            clow_q   <= clow_d;
            chigh_q  <= chigh_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Clow;
    logic [31:0] Chigh;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    seq_divider #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Clow        (Clow),
        .Chigh       (Chigh),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Launches one divide and returns at the negedge of the done cycle; lat=-1 on timeout.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
        end
        checks++;
        if (Clow !== 32'h0 || Chigh !== 32'h0) begin
            failures++;
            $display("FAIL reset_results: got %h/%h expected 0/0", Clow, Chigh);
        end
        clear = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_vectors();
        vec_t v[$];
        int   lat;
        v.push_back('{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34});
        v.push_back('{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34});
        v.push_back('{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34});
        v.push_back('{32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 34});
        v.push_back('{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34});
        v.push_back('{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0, 34});
        v.push_back('{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 34});
        v.push_back('{32'd5,          32'd7,          32'd0,          32'd5,          1'b0, 34});
        v.push_back('{32'd100,        32'd0,          32'hFFFFFFFF,   32'd100,        DZ_EN, DZ_EN ? 2 : 34});
        v.push_back('{32'hFFFFFF9C,   32'd0,          DZ_EN ? 32'hFFFFFFFF : 32'd1, 32'hFFFFFF9C, DZ_EN, DZ_EN ? 2 : 34});
        foreach (v[i]) begin
            run_div(v[i].a, v[i].b, lat);
            checks++;
            if (lat !== v[i].lat) begin
                failures++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
            end
            checks++;
            if (Clow !== v[i].q) begin
                failures++;
                $display("FAIL vec%0d_quotient: got %h expected %h", i, Clow, v[i].q);
            end
            checks++;
            if (Chigh !== v[i].r) begin
                failures++;
                $display("FAIL vec%0d_remainder: got %h expected %h", i, Chigh, v[i].r);
            end
            checks++;
            if (div_by_zero !== v[i].dz) begin
                failures++;
                $display("FAIL vec%0d_div_by_zero: got %b expected %b", i, div_by_zero, v[i].dz);
            end
        end
    endtask

    task automatic test_busy_profile();
        int busy_cnt = 0;
        int done_at  = -1;
        @(negedge clock);
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        A     = 32'd1;
        B     = 32'd1;
        for (int c = 1; c <= 36; c++) begin
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = c;
            if (c == 1 || c == 33) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_cycle%0d: got %b expected 1", c, busy);
                end
            end
            if (c == 34) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    failures++;
                    $display("FAIL done_cycle34: got busy=%b done=%b expected busy=0 done=1", busy, done);
                end
                checks++;
                if (Clow !== 32'd14 || Chigh !== 32'd2) begin
                    failures++;
                    $display("FAIL late_operand_change: got %h/%h expected 0000000e/00000002", Clow, Chigh);
                end
            end
            @(negedge clock);
        end
        checks++;
        if (busy_cnt !== 33 || done_at !== 34) begin
            failures++;
            $display("FAIL busy_profile: got busy_cycles=%0d done_at=%0d expected 33/34", busy_cnt, done_at);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_div(32'd100, 32'd7, lat);
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL relaunch_from_done: got busy=%b done=%b expected 1/0", busy, done);
        end
        checks++;
        if (Clow !== 32'd14 || Chigh !== 32'd2) begin
            failures++;
            $display("FAIL hold_while_busy: got %h/%h expected 0000000e/00000002", Clow, Chigh);
        end
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (lat !== 34 || Clow !== 32'd3 || Chigh !== 32'd0) begin
            failures++;
            $display("FAIL back_to_back: got lat=%0d %h/%h expected 34 00000003/00000000", lat, Clow, Chigh);
        end
    endtask

    task automatic test_abort();
        int lat;
        int stray_done = 0;
        @(negedge clock);
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                A     = 32'd9;
                B     = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) stray_done++;
            @(negedge clock);
        end
        checks++;
        if (busy !== 1'b1 || stray_done !== 0) begin
            failures++;
            $display("FAIL start_ignored_while_busy: got busy=%b dones=%0d expected 1/0", busy, stray_done);
        end
        clear = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || Clow !== 32'h0 || Chigh !== 32'h0) begin
            failures++;
            $display("FAIL abort_reset: got busy=%b %h/%h expected 0 0/0", busy, Clow, Chigh);
        end
        @(negedge clock);
        clear = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done) stray_done++;
            @(negedge clock);
        end
        checks++;
        if (stray_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", stray_done);
        end
        run_div(32'd9, 32'd3, lat);
        checks++;
        if (lat !== 34 || Clow !== 32'd3 || Chigh !== 32'd0) begin
            failures++;
            $display("FAIL after_abort: got lat=%0d %h/%h expected 34 00000003/00000000", lat, Clow, Chigh);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_busy_profile();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
